// File: rtl/ram_pkt_tx_if.sv
// Packet transmitter bus bundle: former handshake, packet RAM read port,
// byte stream towards the UDP/MAC side and status flags.
//   master : the transmitter (drives adr_rd, tx_*, end_tx, busy, crc_err)
//   slave  : the environment (former, packet RAM, byte sink)
interface ram_pkt_tx_if #(
  parameter int unsigned ADR_W = 11
);
  logic             start;
  logic [7:0]       channel;
  logic [15:0]      nbuf;
  logic [31:0]      crc_buf;
  logic [ADR_W-1:0] adr_rd;
  logic [31:0]      q_rd;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_sop;
  logic             tx_eop;
  logic             end_tx;
  logic             busy;
  logic             crc_err;

  modport master (
    input  start, channel, nbuf, crc_buf, q_rd, tx_ready,
    output adr_rd, tx_data, tx_valid, tx_sop, tx_eop, end_tx, busy, crc_err
  );

  modport slave (
    output start, channel, nbuf, crc_buf, q_rd, tx_ready,
    input  adr_rd, tx_data, tx_valid, tx_sop, tx_eop, end_tx, busy, crc_err
  );
endinterface

// File: rtl/ram_pkt_tx.sv
// Packet transmitter: streams a packet held in RAM as bytes.
// Packet = SYNC_BYTE, channel, nbuf[15:8], nbuf[7:0], W=nbuf>>2 RAM words
// (MSB byte first), crc_buf (MSB byte first).
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   io_bus : ram_pkt_tx_if.master (start/channel/nbuf/crc_buf in, RAM read
//            port adr_rd/q_rd, tx_data/tx_valid/tx_ready/tx_sop/tx_eop,
//            end_tx, busy, crc_err)
// Optional macro TX_CRC_CHECK_EN: sums q_rd[31:16]+q_rd[15:0] over the payload
// and flags crc_err when the sum differs from crc_buf.
module ram_pkt_tx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned ADR_W     = 11
) (
  input logic          clk,
  input logic          rst,
  ram_pkt_tx_if.master io_bus
);

  typedef enum logic [2:0] {StIdle, StHdr, StFetch, StPay, StTrl, StDone} state_e;

  state_e           r_state;
  logic [7:0]       r_chan;
  logic [15:0]      r_nbuf;
  logic [31:0]      r_crc;
  logic [31:0]      r_word;
  logic [13:0]      r_widx;
  logic [1:0]       r_bcnt;
  logic [ADR_W-1:0] r_adr;
  logic [7:0]       r_data;
  logic             r_valid, r_sop, r_eop, r_end, r_busy;

  logic [13:0] w_nwords;
  logic        w_adv, w_last_word, w_accept, w_cap, w_fin;
  logic [7:0]  w_hdr_byte, w_pay_byte, w_crc_byte;

  assign w_nwords    = r_nbuf[15:2];
  // Output slot is free or its byte is being taken this cycle.
  assign w_adv       = !r_valid || io_bus.tx_ready;
  assign w_last_word = (r_widx == w_nwords - 14'd1);
  assign w_accept    = (r_state == StIdle) && io_bus.start && !r_busy;
  // Word capture: first word in FETCH, then the prefetched word as the
  // last byte of the current word is loaded.
  assign w_cap       = (r_state == StFetch) ||
                       ((r_state == StPay) && w_adv && (r_bcnt == 2'd3) && !w_last_word);
  assign w_fin       = (r_state == StTrl) && r_eop && io_bus.tx_ready;

  always_comb begin
    w_hdr_byte = SYNC_BYTE;
    w_pay_byte = r_word[31:24];
    w_crc_byte = r_crc[31:24];
    unique case (r_bcnt)
      2'd0: begin
        w_hdr_byte = SYNC_BYTE;
        w_pay_byte = r_word[31:24];
        w_crc_byte = r_crc[31:24];
      end
      2'd1: begin
        w_hdr_byte = r_chan;
        w_pay_byte = r_word[23:16];
        w_crc_byte = r_crc[23:16];
      end
      2'd2: begin
        w_hdr_byte = r_nbuf[15:8];
        w_pay_byte = r_word[15:8];
        w_crc_byte = r_crc[15:8];
      end
      default: begin
        w_hdr_byte = r_nbuf[7:0];
        w_pay_byte = r_word[7:0];
        w_crc_byte = r_crc[7:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_chan  <= '0;
      r_nbuf  <= '0;
      r_crc   <= '0;
      r_word  <= '0;
      r_widx  <= '0;
      r_bcnt  <= '0;
      r_adr   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // A transferred byte empties the slot unless a state reloads it below.
      if (r_valid && io_bus.tx_ready) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
      if (w_cap) begin
        r_word <= io_bus.q_rd;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_chan  <= io_bus.channel;
            r_nbuf  <= io_bus.nbuf;
            r_crc   <= io_bus.crc_buf;
            r_busy  <= 1'b1;
            r_adr   <= '0;
            r_widx  <= '0;
            r_bcnt  <= '0;
            r_state <= StHdr;
          end
        end
        StHdr: begin
          if (w_adv) begin
            r_data  <= w_hdr_byte;
            r_valid <= 1'b1;
            r_sop   <= (r_bcnt == 2'd0);
            r_eop   <= 1'b0;
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_state <= (w_nwords == 14'd0) ? StTrl : StFetch;
            end
          end
        end
        StFetch: begin
          // adr_rd has held word 0 since accept, so q_rd is already valid.
          r_widx  <= '0;
          r_bcnt  <= '0;
          if (w_nwords > 14'd1) begin
            r_adr <= ADR_W'(1);
          end
          r_state <= StPay;
        end
        StPay: begin
          if (w_adv) begin
            r_data  <= w_pay_byte;
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              if (w_last_word) begin
                r_state <= StTrl;
              end else begin
                r_widx <= r_widx + 14'd1;
                // Prefetch one word ahead, never past the last word.
                if (({1'b0, r_widx} + 15'd2) < {1'b0, w_nwords}) begin
                  r_adr <= ADR_W'({1'b0, r_widx} + 15'd2);
                end
              end
            end
          end
        end
        StTrl: begin
          if (r_eop) begin
            if (w_fin) begin
              r_end   <= 1'b1;
              r_state <= StDone;
            end
          end else if (w_adv) begin
            r_data  <= w_crc_byte;
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= (r_bcnt == 2'd3);
            r_bcnt  <= r_bcnt + 2'd1;
          end
        end
        StDone: begin
          r_end   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.adr_rd   = r_adr;
  assign io_bus.tx_data  = r_data;
  assign io_bus.tx_valid = r_valid;
  assign io_bus.tx_sop   = r_sop;
  assign io_bus.tx_eop   = r_eop;
  assign io_bus.end_tx   = r_end;
  assign io_bus.busy     = r_busy;

`ifdef TX_CRC_CHECK_EN
  logic [31:0] r_sum;
  logic        r_crc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum     <= '0;
      r_crc_err <= 1'b0;
    end else if (w_accept) begin
      r_sum     <= '0;
      r_crc_err <= 1'b0;
    end else begin
      if (w_cap) begin
        r_sum <= r_sum + {16'h0, io_bus.q_rd[31:16]} + {16'h0, io_bus.q_rd[15:0]};
      end
      if (w_fin) begin
        r_crc_err <= (r_sum != r_crc);
      end
    end
  end

  assign io_bus.crc_err = r_crc_err;
`else
  assign io_bus.crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_pkt_tx.sv
// Randomized self-checking bench for ram_pkt_tx with a packet-level model.
module tb_ram_pkt_tx;
  localparam int unsigned ADR_W = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_pkt_tx_if #(.ADR_W(ADR_W)) bus ();

  ram_pkt_tx #(.SYNC_BYTE(8'hA5), .ADR_W(ADR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet RAM: registered read, data valid one cycle after the address.
  logic [31:0] mem [0:2047];
  initial begin
    forever begin
      @(posedge clk);
      bus.q_rd <= mem[bus.adr_rd];
    end
  end

  // tx_ready pattern: 0 = always high, 1 = toggle each cycle, 2 = random.
  int rdy_mode = 0;
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ~bus.tx_ready;
        default: bus.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Byte-stream monitor, sampled mid-cycle.
  logic [7:0] got_q [$];
  bit         got_sop [$];
  bit         got_eop [$];
  int         got_cyc [$];
  int         cyc = 0;
  int         n_end = 0;
  int         max_adr = 0;
  bit         prev_stall = 1'b0;
  bit         prev_eop_x = 1'b0;
  logic [9:0] prev_out = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_stall = 1'b0;
        prev_eop_x = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 32'(bus.tx_valid), 32'd1);
          check_eq("hold_data", 32'({bus.tx_sop, bus.tx_eop, bus.tx_data}), 32'(prev_out));
        end
        if (bus.end_tx || prev_eop_x) begin
          check_eq("end_tx_after_eop", 32'(bus.end_tx), 32'(prev_eop_x));
        end
        if (bus.end_tx) n_end++;
        if (bus.busy && (int'(bus.adr_rd) > max_adr)) max_adr = int'(bus.adr_rd);
        prev_eop_x = 1'b0;
        if (bus.tx_valid && bus.tx_ready) begin
          got_q.push_back(bus.tx_data);
          got_sop.push_back(bus.tx_sop);
          got_eop.push_back(bus.tx_eop);
          got_cyc.push_back(cyc);
          prev_eop_x = bus.tx_eop;
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_out   = {bus.tx_sop, bus.tx_eop, bus.tx_data};
      end
    end
  end

  function automatic logic [31:0] model_sum(input int w);
    logic [31:0] s = 32'h0;
    for (int k = 0; k < w; k++) s = s + {16'h0, mem[k][31:16]} + {16'h0, mem[k][15:0]};
    return s;
  endfunction

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_valid"}, 32'(bus.tx_valid), 32'd0);
    check_eq({pfx, "_sop"}, 32'(bus.tx_sop), 32'd0);
    check_eq({pfx, "_eop"}, 32'(bus.tx_eop), 32'd0);
    check_eq({pfx, "_end_tx"}, 32'(bus.end_tx), 32'd0);
    check_eq({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({pfx, "_crc_err"}, 32'(bus.crc_err), 32'd0);
    check_eq({pfx, "_adr_rd"}, 32'(bus.adr_rd), 32'd0);
    check_eq({pfx, "_tx_data"}, 32'(bus.tx_data), 32'd0);
  endtask

  // extra: 0 none, 1 second start mid-payload, 2 start during end_tx,
  //        3 reset at byte 100.
  task automatic send_pkt(input logic [7:0] ch, input logic [15:0] nb, input logic [31:0] crc,
                          input int mode, input int extra);
    logic [7:0]  exp_q [$];
    logic [31:0] w;
    bit          exp_err;
    bit          ended = 1'b0;
    bit          x_done = 1'b0;
    int          nw = int'(nb[15:2]);
    int          gaps = 0;
    int          n_sop = 0;
    int          n_eop = 0;

    exp_q.push_back(8'hA5);
    exp_q.push_back(ch);
    exp_q.push_back(nb[15:8]);
    exp_q.push_back(nb[7:0]);
    for (int k = 0; k < nw; k++) begin
      w = mem[k];
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    exp_q.push_back(crc[31:24]);
    exp_q.push_back(crc[23:16]);
    exp_q.push_back(crc[15:8]);
    exp_q.push_back(crc[7:0]);
`ifdef TX_CRC_CHECK_EN
    exp_err = (model_sum(nw) != crc);
`else
    exp_err = 1'b0;
`endif

    rdy_mode = mode;
    @(posedge clk);
    #1;
    got_q.delete();
    got_sop.delete();
    got_eop.delete();
    got_cyc.delete();
    n_end   = 0;
    max_adr = 0;
    bus.channel = ch;
    bus.nbuf    = nb;
    bus.crc_buf = crc;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.channel = 8'($urandom);
    bus.nbuf    = 16'($urandom);
    bus.crc_buf = $urandom;
    check_eq("busy_after_start", 32'(bus.busy), 32'd1);
    check_eq("crc_err_cleared", 32'(bus.crc_err), 32'd0);

    for (int t = 0; t < 20000; t++) begin
      @(posedge clk);
      #1;
      if (bus.end_tx) begin
        ended = 1'b1;
        check_eq("crc_err_at_end", 32'(bus.crc_err), 32'(exp_err));
        if (extra == 2) begin
          bus.start = 1'b1;
          bus.nbuf  = 16'd8;
          @(posedge clk);
          #1;
          bus.start = 1'b0;
        end
        break;
      end
      if (extra == 1 && !x_done && got_q.size() == 40) begin
        x_done = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      if (extra == 3 && got_q.size() == 100) begin
        #1;
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        check_eq("abort_no_end_tx", 32'(n_end), 32'd0);
        foreach (got_eop[i]) if (got_eop[i]) n_eop++;
        check_eq("abort_no_eop", 32'(n_eop), 32'd0);
        return;
      end
    end
    check_eq("end_tx_seen", 32'(ended), 32'd1);

    repeat ((extra != 0) ? 20 : 2) @(posedge clk);
    #1;
    check_eq("busy_after_end", 32'(bus.busy), 32'd0);
    check_eq("n_end_tx", 32'(n_end), 32'd1);
    check_eq("crc_err_sticky", 32'(bus.crc_err), 32'(exp_err));
    check_eq("length", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    foreach (got_sop[i]) if (got_sop[i]) n_sop++;
    foreach (got_eop[i]) if (got_eop[i]) n_eop++;
    check_eq("sop_count", 32'(n_sop), 32'd1);
    check_eq("eop_count", 32'(n_eop), 32'd1);
    if (got_q.size() > 0) begin
      check_eq("sop_first", 32'(got_sop[0]), 32'd1);
      check_eq("eop_last", 32'(got_eop[got_eop.size()-1]), 32'd1);
    end
    if (nw > 0) check_eq("adr_max", 32'(max_adr), 32'(nw - 1));
    if (mode == 0 && nw > 0 && got_cyc.size() >= 4 + 4 * nw) begin
      for (int i = 4; i < 3 + 4 * nw; i++) if (got_cyc[i+1] != got_cyc[i] + 1) gaps++;
      check_eq("payload_gaps", 32'(gaps), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] s;
    int          nbr;
    bus.start   = 1'b0;
    bus.channel = '0;
    bus.nbuf    = '0;
    bus.crc_buf = '0;
    for (int k = 0; k < 2048; k++) mem[k] = 32'h0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    #2;
    rst = 1'b1;

    // Reference packet: 360 words {k, 0001}, full-rate and toggling ready.
    for (int k = 0; k < 360; k++) mem[k] = {16'(k), 16'h0001};
    s = model_sum(360);
    send_pkt(8'h3C, 16'd1440, s, 0, 0);
    send_pkt(8'h3C, 16'd1440, s, 1, 0);

    // Header-only and one-word packets.
    send_pkt(8'h11, 16'd2, 32'hDEADBEEF, 0, 0);
    send_pkt(8'h12, 16'd3, 32'h0, 2, 0);
    send_pkt(8'h13, 16'd7, model_sum(1), 1, 0);

    // Starts while busy and at end_tx are ignored.
    send_pkt(8'h21, 16'd1440, s, 2, 1);
    send_pkt(8'h22, 16'd16, model_sum(4), 0, 2);

    // Reset mid-packet, then a clean packet.
    send_pkt(8'h31, 16'd1440, s, 0, 3);
    send_pkt(8'h32, 16'd64, model_sum(16), 2, 0);

    // Checksum off by one, then correct.
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    send_pkt(8'h41, 16'd64, model_sum(16) + 32'd1, 0, 0);
    send_pkt(8'h42, 16'd64, model_sum(16), 2, 0);

    for (int r = 0; r < 6; r++) begin
      nbr = $urandom_range(0, 300);
      for (int k = 0; k < 75; k++) mem[k] = $urandom;
      s = model_sum(nbr / 4);
      if ($urandom_range(0, 1) == 1) s = $urandom;
      send_pkt(8'($urandom), 16'(nbr), s, $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_pkt_tx.md
RAM_PKT_TX -- requirements
Module: ram_pkt_tx

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, first header byte of every packet.
REQ-002 Parameter ADR_W, default 11, packet RAM read-address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse from the packet former: RAM holds a complete packet.
REQ-006 channel  input  8  source FIFO index; sampled on accepted start.
REQ-007 nbuf  input  16  payload length in bytes; sampled on accepted start.
REQ-008 crc_buf  input  32  former's checksum; sampled on accepted start.
REQ-009 adr_rd  output  ADR_W  packet RAM read address.
REQ-010 q_rd  input  32  packet RAM read data; valid exactly 1 cycle after adr_rd.
REQ-011 tx_data  output  8  byte stream to the UDP/MAC side.
REQ-012 tx_valid / tx_ready  output / input  1 / 1  byte handshake; transfer when both are high.
REQ-013 tx_sop / tx_eop  output  1 / 1  qualify the first and last byte of a packet.
REQ-014 end_tx  output  1  one-cycle pulse: packet fully sent, former may refill RAM.
REQ-015 busy  output  1  high from accepted start until end_tx.
REQ-016 crc_err  output  1  sticky checksum-mismatch flag; cleared by the next accepted start.

Function
REQ-017 FSM states: IDLE, HDR, FETCH, PAY, TRL, DONE.
REQ-018 IDLE: start accepted only when busy=0; accepting latches channel, nbuf, crc_buf, sets busy, goes to HDR.
REQ-019 start while busy=1 is ignored; it has no effect on the packet in flight.
REQ-020 HDR sends 4 bytes: SYNC_BYTE, channel, nbuf[15:8], nbuf[7:0]; tx_sop marks the SYNC_BYTE.
REQ-021 Word count W = nbuf>>2; nbuf[1:0] is ignored; W=0 goes from HDR straight to TRL.
REQ-022 FETCH drives adr_rd = word index (0..W-1), captures q_rd one cycle later, then enters PAY.
REQ-023 PAY sends the captured word MSB byte first ([31:24], [23:16], [15:8], [7:0]).
REQ-024 The next word is prefetched during PAY, so payload has no idle gap when tx_ready stays high.
REQ-025 After word W-1, TRL sends latched crc_buf MSB byte first; tx_eop marks its byte [7:0].
REQ-026 tx_data, tx_sop and tx_eop hold stable while tx_valid=1 and tx_ready=0.
REQ-027 tx_valid deasserts only after a transfer; tx_ready low for any duration stalls without data loss.
REQ-028 DONE pulses end_tx for exactly 1 cycle on the cycle after the last byte transfers, clears busy, returns to IDLE.
REQ-029 Total bytes per packet = 8 + 4*W; adr_rd never exceeds W-1; the address counter does not wrap within a packet.
REQ-030 start arriving in the same cycle as end_tx is ignored.

Reset
REQ-031 rst low asynchronously forces IDLE; tx_valid, tx_sop, tx_eop, end_tx, busy, crc_err = 0; adr_rd = 0; tx_data = 0.
REQ-032 rst asserted mid-packet aborts the packet; no end_tx and no eop are issued for it.
REQ-033 After rst releases, the first accepted start begins a fresh packet.

Configuration
REQ-034 Macro TX_CRC_CHECK_EN: when defined, the block sums q_rd[31:16]+q_rd[15:0] over all W words (32-bit, wraps mod 2^32, starts at 0).
REQ-035 With TX_CRC_CHECK_EN, at DONE crc_err is set if the sum differs from the latched crc_buf; the packet is still sent unchanged.
REQ-036 Without TX_CRC_CHECK_EN, no accumulator is built and crc_err is constant 0.

Verification
REQ-037 nbuf=1440, RAM word k = {k[15:0], 16'h0001}, tx_ready=1 -> A5, ch, 05, A0, 360 words MSB-first, crc_buf; 1448 bytes; end_tx 1 cycle after eop.
REQ-038 Same packet, tx_ready toggled 1-0-1-0 each cycle -> identical byte sequence, data held stable during stalls, no duplicated or lost bytes.
REQ-039 nbuf=2 -> header 00 02, no RAM reads, trailer follows header directly; total 8 bytes.
REQ-040 Second start pulse during payload -> ignored; one packet only, one end_tx.
REQ-041 rst low at byte 100 -> all outputs 0 immediately; a new start after release -> clean packet starting with tx_sop on A5.
REQ-042 TX_CRC_CHECK_EN defined, crc_buf off by 1 -> crc_err=1 at end_tx; next start with correct crc_buf -> crc_err clears and stays 0.
